mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single external 8-bit memory bus between the CPU and one secondary bus master, such as a DMA or video fetch unit. It sequences each memory access: strobes, wait states, read-data capture and completion signalling. It drives the CPU's `n_mem_rdy` wait input, so the control unit stalls until its access completes. It sits between the CPU core and the memory devices.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width
- `WAIT_STATES`, 1, extra strobe cycles per access; legal range 0..15

Ports:
- `clk` in 1: clock; all state changes on posedge.
- `rst` in 1: reset; synchronous, active-high.
- `cpu_req` in 1: CPU requests an access; held until completion.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr` in `ADDR_W`: CPU address.
- `cpu_wdata` in `DATA_W`: CPU write data.
- `cpu_rdata` out `DATA_W`: read data, valid while `n_mem_rdy` is low.
- `n_mem_rdy` out 1: active-low one-cycle completion pulse to the control unit.
- `dma_req` in 1: secondary master request; held until ack.
- `dma_we` in 1: 1 = write, 0 = read.
- `dma_addr` in `ADDR_W`: secondary master address.
- `dma_wdata` in `DATA_W`: secondary master write data.
- `dma_rdata` out `DATA_W`: read data, valid while `dma_ack` is high.
- `dma_ack` out 1: active-high one-cycle completion pulse.
- `mem_addr` out `ADDR_W`: external address bus.
- `mem_wdata` out `DATA_W`: external write data.
- `mem_rdata` in `DATA_W`: external read data.
- `n_mem_oe` out 1: active-low memory output enable.
- `n_mem_we` out 1: active-low memory write enable.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE. A 4-bit wait counter `wcnt` and a `last_grant` bit (0 = CPU, 1 = DMA) complete the state.
- **IDLE:** sample `cpu_req` and `dma_req`.
  - If neither is high, stay in IDLE.
  - Otherwise, arbitrate (see Configuration).
  - Latch the winner's `we`, `addr` and `wdata` into internal registers.
  - Set `owner`, set `last_grant = owner`, load `wcnt = WAIT_STATES`, and go to ACCESS.
- **ACCESS:**
  - `mem_addr` and `mem_wdata` are driven from the latched registers.
  - For a read, `n_mem_oe` = 0. For a write, `n_mem_we` = 0.
  - If `wcnt == 0`: capture `mem_rdata` into the owner's rdata register on a read, then go to DONE.
  - Otherwise, decrement `wcnt`.
- **DONE:**
  - Both strobes are high. The address stays driven from the latch.
  - Pulse the owner's completion signal: `n_mem_rdy` = 0 for the CPU, `dma_ack` = 1 for DMA.
  - Go to IDLE. Requests are not sampled in DONE.
- **Request rules for masters:**
  - A master deasserts `req` at the edge ending DONE. A `req` still high in the following IDLE is a new request.
  - A master never withdraws `req` before completion.
- The latched request registers isolate the bus from input changes during an access. Inputs changing mid-access have no effect.
- The non-owner's completion output stays inactive. Its rdata register holds its previous value.
- All outputs are registered or decoded from registered state only. There are no combinational paths from `*_req` to memory strobes.

## Timing
- **Values after `rst`:** state IDLE; `n_mem_oe` = `n_mem_we` = 1; `n_mem_rdy` = 1; `dma_ack` = 0; `mem_addr`, `mem_wdata`, `cpu_rdata` and `dma_rdata` all 0; `last_grant` = 1 (DMA), so the first contested grant goes to the CPU.
- **Latency:**
  - Request high in IDLE cycle 0.
  - ACCESS occupies cycles 1..`WAIT_STATES`+1.
  - DONE is cycle `WAIT_STATES`+2.
  - The next grant is possible at cycle `WAIT_STATES`+4 (one IDLE turnaround cycle).
- **Throughput:** one access per `WAIT_STATES`+3 cycles. Strobes are guaranteed high for at least 2 cycles between accesses.
- **`WAIT_STATES` = 0:** ACCESS lasts exactly 1 cycle.
- **Reset mid-access:** `rst` in ACCESS or DONE aborts the access. Strobes go high at the next edge and no completion pulse is issued. The master must re-request.
- **Requests arriving during ACCESS or DONE:** held pending by the master and arbitrated in the next IDLE.

## Configuration
- **`MEM_BUS_ARBITER_RR_EN` defined:** round-robin arbitration.
  - When both masters request in IDLE, the grant goes to the master ≠ `last_grant`.
  - A single requester is always granted.
- **Macro undefined:** fixed priority. The CPU always wins a contested IDLE. `last_grant` is still maintained but unused for arbitration.

## Test plan
- **CPU read:** `WAIT_STATES`=1, `rst` released, CPU read at 0x1234, `mem_rdata`=0xA5.
  - `n_mem_oe` low in cycles 1-2, `mem_addr`=0x1234.
  - `n_mem_rdy` low only in cycle 3, `cpu_rdata`=0xA5.
- **DMA write:** `WAIT_STATES`=0, DMA write 0x5A to 0x8000.
  - `n_mem_we` low for exactly 1 cycle with `mem_wdata`=0x5A.
  - `dma_ack` high 1 cycle later; `n_mem_oe` stays high.
- **Contention:** both masters request continuously for 4 accesses.
  - RR_EN defined: grants are CPU, DMA, CPU, DMA.
  - RR_EN undefined: all 4 grants go to the CPU and `dma_ack` never pulses.
- **Mid-access reset:** `WAIT_STATES`=3, `rst` asserted in the 2nd ACCESS cycle.
  - Strobes high at the next edge.
  - No `n_mem_rdy` or `dma_ack` pulse.
  - All outputs at reset values.
- **Input isolation:** change `cpu_addr` from 0x1000 to 0x2000 mid-access.
  - `mem_addr` stays 0x1000 through ACCESS and DONE.
- **Back-to-back CPU requests:** `WAIT_STATES`=2.
  - Consecutive `n_mem_rdy` pulses are exactly 5 cycles apart.
  - Strobes are high for at least 2 cycles between accesses.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between mem_bus_arbiter, its two requesting masters and the external memory.
// The arbiter connects through the slave modport; the environment side uses master.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              n_mem_rdy;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              n_mem_oe;
    logic              n_mem_we;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, n_mem_rdy,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_addr, mem_wdata, n_mem_oe, n_mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, n_mem_rdy,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_addr, mem_wdata, n_mem_oe, n_mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between the CPU and one secondary master, sequencing strobes,
// wait states and completion. Define MEM_BUS_ARBITER_RR_EN for round-robin; default is CPU priority.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);
    localparam int unsigned WCNT_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
    logic                n_oe_q, n_oe_d;
    logic                n_we_q, n_we_d;
    logic                n_rdy_q, n_rdy_d;
    logic                ack_q, ack_d;
    logic                pick_dma;

    // Winner selection for a request sampled in IDLE
`ifdef MEM_BUS_ARBITER_RR_EN
    assign pick_dma = bus.dma_req && (!bus.cpu_req || !last_grant_q);
`else
    assign pick_dma = bus.dma_req && !bus.cpu_req;
`endif

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        n_oe_d       = 1'b1;
        n_we_d       = 1'b1;
        n_rdy_d      = 1'b1;
        ack_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    owner_d      = pick_dma;
                    last_grant_d = pick_dma;
                    we_d         = pick_dma ? bus.dma_we    : bus.cpu_we;
                    addr_d       = pick_dma ? bus.dma_addr  : bus.cpu_addr;
                    wdata_d      = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
                    wcnt_d       = WCNT_W'(WAIT_STATES);
                    n_oe_d       = we_d;
                    n_we_d       = !we_d;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (wcnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q) dma_rdata_d = bus.mem_rdata;
                        else         cpu_rdata_d = bus.mem_rdata;
                    end
                    // Owner 0 is the CPU: its ready is active-low, the DMA ack active-high
                    n_rdy_d = owner_q;
                    ack_d   = owner_q;
                    state_d = DONE;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                    n_oe_d = we_q;
                    n_we_d = !we_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            n_oe_q       <= 1'b1;
            n_we_q       <= 1'b1;
            n_rdy_q      <= 1'b1;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            n_oe_q       <= n_oe_d;
            n_we_q       <= n_we_d;
            n_rdy_q      <= n_rdy_d;
            ack_q        <= ack_d;
        end
    end

    // The latched address/data registers drive the bus directly
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.n_mem_oe  = n_oe_q;
    assign bus.n_mem_we  = n_we_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.n_mem_rdy = n_rdy_q;
    assign bus.dma_ack   = ack_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a cycle-count
// reference model (cycles elapsed since grant) of the access timeline.
module tb_mem_bus_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int WS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mk = cycles since the grant edge (0 = idle)
    int          mk       = 0;
    bit          m_owner  = 1'b0;
    bit          m_we     = 1'b0;
    bit          m_last   = 1'b1;
    logic [15:0] m_addr   = '0;
    logic [7:0]  m_wdata  = '0;
    logic [7:0]  m_cpu_rd = '0;
    logic [7:0]  m_dma_rd = '0;

    // Observation statistics
    int cyc = 0, oe_lo = 0, we_lo = 0, rdy_cnt = 0, ack_cnt = 0;
    int hi_run = 0, min_gap = 1000, last_rdy = -1, rdy_gap = 0;
    bit prev_low = 1'b0, seen_acc = 1'b0, new_gap = 1'b0;
    int obs_grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit pick;
        if (rst) begin
            mk = 0; m_owner = 0; m_we = 0; m_last = 1;
            m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dma_rd = '0;
        end else if (mk == 0) begin
            if (bus.cpu_req || bus.dma_req) begin
`ifdef MEM_BUS_ARBITER_RR_EN
                pick = bus.dma_req && (!bus.cpu_req || !m_last);
`else
                pick = bus.dma_req && !bus.cpu_req;
`endif
                m_owner = pick;
                m_last  = pick;
                m_we    = pick ? bus.dma_we    : bus.cpu_we;
                m_addr  = pick ? bus.dma_addr  : bus.cpu_addr;
                m_wdata = pick ? bus.dma_wdata : bus.cpu_wdata;
                mk = 1;
            end
        end else if (mk <= WS + 1) begin
            if (mk == WS + 1 && !m_we) begin
                if (m_owner) m_dma_rd = bus.mem_rdata;
                else         m_cpu_rd = bus.mem_rdata;
            end
            mk++;
        end else begin
            mk = 0;
        end
    endtask

    task automatic clear_stats();
        oe_lo = 0; we_lo = 0; rdy_cnt = 0; ack_cnt = 0;
        hi_run = 0; min_gap = 1000; last_rdy = -1; prev_low = 0; seen_acc = 0;
        obs_grants.delete();
    endtask

    // One clock: advance model at posedge, compare every output at negedge
    task automatic tick();
        bit acc, done, low;
        @(posedge clk);
        model_update();
        @(negedge clk);
        acc  = (mk >= 1 && mk <= WS + 1);
        done = (mk == WS + 2);
        chk("n_mem_oe",  32'(bus.n_mem_oe),  32'(!(acc && !m_we)));
        chk("n_mem_we",  32'(bus.n_mem_we),  32'(!(acc && m_we)));
        chk("n_mem_rdy", 32'(bus.n_mem_rdy), 32'(!(done && !m_owner)));
        chk("dma_ack",   32'(bus.dma_ack),   32'(done && m_owner));
        chk("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
        chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_cpu_rd));
        chk("dma_rdata", 32'(bus.dma_rdata), 32'(m_dma_rd));
        cyc++;
        if (!bus.n_mem_oe) oe_lo++;
        if (!bus.n_mem_we) we_lo++;
        low = !bus.n_mem_oe || !bus.n_mem_we;
        if (low && !prev_low) begin
            if (seen_acc && hi_run < min_gap) min_gap = hi_run;
            seen_acc = 1;
        end
        hi_run   = low ? 0 : hi_run + 1;
        prev_low = low;
        new_gap  = 0;
        if (!bus.n_mem_rdy) begin
            rdy_cnt++;
            obs_grants.push_back(0);
            new_gap  = (last_rdy >= 0);
            rdy_gap  = cyc - last_rdy;
            last_rdy = cyc;
        end
        if (bus.dma_ack) begin
            ack_cnt++;
            obs_grants.push_back(1);
        end
    endtask

    task automatic new_cpu();
        bus.cpu_req = 1; bus.cpu_we = 1'($urandom);
        bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 8'($urandom);
    endtask

    task automatic new_dma();
        bus.dma_req = 1; bus.dma_we = 1'($urandom);
        bus.dma_addr = 16'($urandom); bus.dma_wdata = 8'($urandom);
    endtask

    // Masters hold req until their completion; at completion re-request (keep) or drop
    task automatic master_update(input bit rnd, input bit keep);
        bit c_done, d_done;
        c_done = (mk == WS + 2) && !m_owner;
        d_done = (mk == WS + 2) && m_owner;
        if (c_done) begin
            if (keep) new_cpu(); else bus.cpu_req = 0;
        end else if (rnd && !bus.cpu_req && $urandom_range(0, 2) == 0) new_cpu();
        if (d_done) begin
            if (keep) new_dma(); else bus.dma_req = 0;
        end else if (rnd && !bus.dma_req && $urandom_range(0, 2) == 0) new_dma();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int exp_g;
        rst = 1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.mem_rdata = '0;
        repeat (3) tick();
        chk("rst_oe",  32'(bus.n_mem_oe), 32'(1));
        chk("rst_rdy", 32'(bus.n_mem_rdy), 32'(1));
        chk("rst_ack", 32'(bus.dma_ack), 32'(0));
        rst = 0;

        // CPU read at 0x1234 returning 0xA5
        clear_stats();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h1234; bus.mem_rdata = 8'hA5;
        repeat (WS + 2) tick();
        chk("rd_rdy",   32'(bus.n_mem_rdy), 32'(0));
        chk("rd_data",  32'(bus.cpu_rdata), 32'(8'hA5));
        chk("rd_addr",  32'(bus.mem_addr), 32'(16'h1234));
        chk("rd_oe_lo", 32'(oe_lo), 32'(WS + 1));
        bus.cpu_req = 0;
        tick();
        chk("rd_rdy_n", 32'(rdy_cnt), 32'(1));

        // DMA write 0x5A to 0x8000
        clear_stats();
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h8000; bus.dma_wdata = 8'h5A;
        tick();
        chk("wr_wdata", 32'(bus.mem_wdata), 32'(8'h5A));
        repeat (WS + 1) tick();
        chk("wr_ack",   32'(bus.dma_ack), 32'(1));
        chk("wr_we_lo", 32'(we_lo), 32'(WS + 1));
        chk("wr_oe_lo", 32'(oe_lo), 32'(0));
        bus.dma_req = 0;
        tick();
        chk("wr_ack_n", 32'(ack_cnt), 32'(1));

        // Contention: both request continuously for four accesses
        clear_stats();
        new_cpu(); new_dma();
        for (int i = 0; i < 80; i++) begin
            tick();
            master_update(0, obs_grants.size() < 4);
            if (!bus.cpu_req && !bus.dma_req && mk == 0) break;
        end
        chk("ct_count", 32'(obs_grants.size() >= 4), 32'(1));
        for (int i = 0; i < 4 && i < obs_grants.size(); i++) begin
`ifdef MEM_BUS_ARBITER_RR_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            chk($sformatf("ct_grant%0d", i), 32'(obs_grants[i]), 32'(exp_g));
        end

        // Reset during the second ACCESS cycle of a CPU write
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h4321; bus.cpu_wdata = 8'h77;
        repeat (2) tick();
        chk("mr_we_lo", 32'(bus.n_mem_we), 32'(0));
        rst = 1; bus.cpu_req = 0;
        clear_stats();
        tick();
        chk("mr_we",   32'(bus.n_mem_we), 32'(1));
        chk("mr_oe",   32'(bus.n_mem_oe), 32'(1));
        chk("mr_addr", 32'(bus.mem_addr), 32'(0));
        chk("mr_crd",  32'(bus.cpu_rdata), 32'(0));
        rst = 0;
        repeat (WS + 4) tick();
        chk("mr_pulses", 32'(rdy_cnt + ack_cnt), 32'(0));

        // Input isolation: address change mid-access is ignored
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h1000;
        tick();
        bus.cpu_addr = 16'h2000;
        for (int i = 0; i < WS + 1; i++) begin
            tick();
            chk("iso_addr", 32'(bus.mem_addr), 32'(16'h1000));
        end
        chk("iso_rdy", 32'(bus.n_mem_rdy), 32'(0));
        bus.cpu_req = 0;
        tick();

        // Back-to-back CPU requests
        clear_stats();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0042;
        for (int i = 0; i < 6 * (WS + 3); i++) begin
            tick();
            if (new_gap) chk("b2b_gap", 32'(rdy_gap), 32'(WS + 3));
            if (mk == WS + 2) begin
                if (rdy_cnt >= 3) bus.cpu_req = 0;
            end
            if (!bus.cpu_req && mk == 0) break;
        end
        chk("b2b_count", 32'(rdy_cnt), 32'(3));
        chk("b2b_hi2",   32'(min_gap >= 2), 32'(1));

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bus.mem_rdata = 8'($urandom);
            rst = ($urandom_range(0, 79) == 0);
            tick();
            master_update(1, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
